qmax_updater: RTL

QMAX_UPDATER -- requirements
Module: qmax_updater

---
 rtl/qmax_pkg.sv | 27 ++
 rtl/fp32_gt.sv | 20 ++
 rtl/qmax_updater.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/qmax_pkg.sv
// Shared definitions for the Q-max updater: FSM encoding, fp32 field layout
// and the sign-magnitude to unsigned ordering key used by the comparator.
package qmax_pkg;

  localparam int FP32_W      = 32;
  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  localparam logic [FP32_W-1:0] FP32_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Negatives are bit-inverted, positives get the top bit set, so that a
  // plain unsigned compare of keys follows the fp32 total order.
  function automatic logic [FP32_W-1:0] fp32_order_key(input logic [FP32_W-1:0] v);
    logic [FP32_W-1:0] k;
    if (v[FP32_W-FP32_SIGN_W]) k = ~v;
    else                       k = v | {1'b1, {(FP32_W-1){1'b0}}};
    return k;
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational fp32 greater-than: total order, +0 == -0, a NaN in 'a'
// never compares greater.
module fp32_gt
  import qmax_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              a_gt_b
);

  localparam int EXP_HI = FP32_W - FP32_SIGN_W - 1;

  logic a_nan;
  logic both_zero;

  assign a_nan     = (a[EXP_HI -: FP32_EXP_W] == '1) && (a[FP32_MANT_W-1:0] != '0);
  assign both_zero = (a[EXP_HI:0] == '0) && (b[EXP_HI:0] == '0);
  assign a_gt_b    = !a_nan && !both_zero && (fp32_order_key(a) > fp32_order_key(b));

endmodule

// File: rtl/qmax_updater.sv
// Keeps a per-state running max of fp32 Q candidates in an external table:
// read at accept, compare one cycle later, write back on a strict win.
module qmax_updater
  import qmax_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  input  logic                  i_clear,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_r,
  output logic                  o_tbl_read_en,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr_w,
  output logic                  o_tbl_write_en,
  output logic [DATA_WIDTH-1:0] o_tbl_data,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_qmax,
  output logic                  o_updated,
  output logic                  o_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_we;

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_state_q;
  logic [DATA_WIDTH-1:0] s1_cand_q;
  logic                  s2_valid_q;
  logic [ADDR_WIDTH-1:0] s2_state_q;
  logic [DATA_WIDTH-1:0] s2_qmax_q;
  logic                  s2_upd_q;
  logic                  s3_valid_q;
  logic [ADDR_WIDTH-1:0] s3_state_q;
  logic [DATA_WIDTH-1:0] s3_qmax_q;

  logic                  accept;
  logic                  pipe_empty;
  logic [DATA_WIDTH-1:0] stored;
  logic                  cand_wins;

  assign accept        = i_valid && o_ready;
  assign o_tbl_read_en = accept;
  assign o_tbl_addr_r  = i_state;
  assign pipe_empty    = !s1_valid_q && !s2_valid_q && !s3_valid_q;

  // The table read lags the two most recent results; forward them, newest first.
  always_comb begin
    stored = i_tbl_data;
    if (s2_valid_q && (s2_state_q == s1_state_q))      stored = s2_qmax_q;
    else if (s3_valid_q && (s3_state_q == s1_state_q)) stored = s3_qmax_q;
  end

  fp32_gt u_gt (
    .a      (s1_cand_q),
    .b      (stored),
    .a_gt_b (cand_wins)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_state_q <= '0;
      s1_cand_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_state_q <= '0;
      s2_qmax_q  <= '0;
      s2_upd_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_state_q <= '0;
      s3_qmax_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_state_q <= i_state;
        s1_cand_q  <= i_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_upd_q   <= s1_valid_q && cand_wins;
      if (s1_valid_q) begin
        s2_state_q <= s1_state_q;
        s2_qmax_q  <= cand_wins ? s1_cand_q : stored;
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_state_q <= s2_state_q;
        s3_qmax_q  <= s2_qmax_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RUN;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    o_ready    = 1'b0;
    o_busy     = 1'b1;
    clr_we     = 1'b0;
    case (state_q)
      ST_RUN: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_clear) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign o_tbl_write_en = clr_we || (s2_valid_q && s2_upd_q);
  assign o_tbl_addr_w   = clr_we ? clr_addr_q : s2_state_q;
  assign o_tbl_data     = clr_we ? FP32_ZERO : s2_qmax_q;

  assign o_done    = s2_valid_q;
  assign o_qmax    = s2_qmax_q;
  assign o_updated = s2_upd_q;

endmodule
